// File: rtl/usb_mon_pkg.sv
// Shared types and frame-number helpers for the USB host-presence monitor.
package usb_mon_pkg;

    localparam int FRAME_W = 11;
    localparam logic [FRAME_W-1:0] FRAME_MASK = 11'h7FF;

    typedef enum logic [1:0] {
        ABSENT,
        ACQUIRE,
        PRESENT,
        SUSPENDED
    } mon_state_e;

    function automatic logic [FRAME_W-1:0] frame_inc(input logic [FRAME_W-1:0] f);
        return (f + 11'd1) & FRAME_MASK;
    endfunction

endpackage

// File: rtl/usb_frame_tick_gen.sv
// Local 1 ms frame clock: real ticks on SOF, synthetic ticks when an SOF is
// missing, and the local frame number that follows either.
module usb_frame_tick_gen
    import usb_mon_pkg::*;
#(
    parameter int WINDOW_CYCLES = 48000,
    parameter int TOL_CYCLES    = 480
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run_i,
    input  logic               sof_i,
    input  logic               real_tick_i,
    input  logic [FRAME_W-1:0] frame_i,
    output logic               synth_fire_o,
    output logic               in_window_o,
    output logic [FRAME_W-1:0] frame_exp_o,
    output logic               frame_tick_o,
    output logic               frame_synth_o,
    output logic [FRAME_W-1:0] local_frame_o
);

    localparam int TW = $clog2(WINDOW_CYCLES + TOL_CYCLES + 1);
    localparam logic [TW-1:0] FIRE_AT_T = TW'(WINDOW_CYCLES + TOL_CYCLES - 1);
    localparam logic [TW-1:0] LO_T      = TW'(WINDOW_CYCLES - TOL_CYCLES - 1);
    localparam logic [TW-1:0] RELOAD_T  = TW'(TOL_CYCLES);

    logic [TW-1:0]      tick_q, tick_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               tick_out_q, tick_out_d;
    logic               synth_q, synth_d;

    // tick_q + 1 is the interval since the last real or synthesised frame start
    assign synth_fire_o = run_i && !sof_i && (tick_q == FIRE_AT_T);
    assign in_window_o  = (tick_q >= LO_T) && (tick_q <= FIRE_AT_T);
    assign frame_exp_o  = frame_inc(frame_q);

    always_comb begin
        tick_d     = tick_q + TW'(1);
        frame_d    = frame_q;
        tick_out_d = real_tick_i || synth_fire_o;
        synth_d    = synth_fire_o;
        if (sof_i || !run_i) begin
            tick_d = '0;
        end else if (synth_fire_o) begin
            // Reload with the tolerance so the next synthetic tick stays on the
            // nominal frame grid rather than drifting by TOL each frame.
            tick_d = RELOAD_T;
        end
        if (sof_i) begin
            frame_d = frame_i;
        end else if (synth_fire_o) begin
            frame_d = frame_inc(frame_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q     <= '0;
            frame_q    <= '0;
            tick_out_q <= 1'b0;
            synth_q    <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            frame_q    <= frame_d;
            tick_out_q <= tick_out_d;
            synth_q    <= synth_d;
        end
    end

    assign frame_tick_o  = tick_out_q;
    assign frame_synth_o = synth_q;
    assign local_frame_o = frame_q;

endmodule

// File: rtl/usb_host_monitor.sv
// Host-presence monitor: qualifies SOF traffic into present/suspended/timeout
// status and keeps a frame clock that survives missed SOFs.
module usb_host_monitor
    import usb_mon_pkg::*;
#(
    parameter int WINDOW_CYCLES  = 48000,
    parameter int TOL_CYCLES     = 480,
    parameter int TIMEOUT_CYCLES = 196000000,
    parameter int PRESENT_SOFS   = 4,
    parameter int SUSPEND_FRAMES = 3,
    parameter int MISS_W         = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sof_valid,
    input  logic [FRAME_W-1:0] frame_index,
    input  logic               bus_reset,
    input  logic               clear_stats,
    output logic               host_present,
    output logic               host_timeout,
    output logic               suspended,
    output logic               frame_tick,
    output logic               frame_synth,
    output logic [FRAME_W-1:0] local_frame,
    output logic               frame_err,
    output logic [MISS_W-1:0]  missed_frames
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
    localparam int AW = $clog2(PRESENT_SOFS + 1);
    localparam int SW = $clog2(SUSPEND_FRAMES + 1);

    mon_state_e         state_q, state_d;
    logic [AW-1:0]      acq_q, acq_d, acq_next;
    logic [SW-1:0]      miss_run_q, miss_run_d;
    logic [TW-1:0]      sof_timer_q, sof_timer_d;
    logic               host_present_q, host_present_d;
    logic               host_timeout_q, host_timeout_d;
    logic               suspended_q, suspended_d;
    logic               frame_err_q, frame_err_d;
    logic [MISS_W-1:0]  missed_q, missed_d;

    logic               sof;
    logic               timeout_hit;
    logic               acq_in_window;
    logic               run;
    logic               real_tick;
    logic               synth_fire;
    logic               tick_in_window;
    logic [FRAME_W-1:0] frame_exp;

    // bus_reset swallows a coincident SOF; a coincident SOF defers the timeout
    assign sof           = sof_valid && !bus_reset;
    assign timeout_hit   = !sof_valid && !bus_reset && (32'(sof_timer_q) > TIMEOUT_CYCLES);
    assign acq_in_window = (32'(sof_timer_q) >= WINDOW_CYCLES - TOL_CYCLES - 1) &&
                           (32'(sof_timer_q) <= WINDOW_CYCLES + TOL_CYCLES - 1);
    assign acq_next      = acq_in_window ? acq_q + AW'(1) : AW'(1);
    assign run           = ((state_q == PRESENT) || (state_q == SUSPENDED)) &&
                           !timeout_hit && !bus_reset;
    assign real_tick     = sof && (state_q == PRESENT);

    usb_frame_tick_gen #(
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .TOL_CYCLES    (TOL_CYCLES)
    ) u_tick_gen (
        .clk           (clk),
        .reset_n       (reset_n),
        .run_i         (run),
        .sof_i         (sof),
        .real_tick_i   (real_tick),
        .frame_i       (frame_index),
        .synth_fire_o  (synth_fire),
        .in_window_o   (tick_in_window),
        .frame_exp_o   (frame_exp),
        .frame_tick_o  (frame_tick),
        .frame_synth_o (frame_synth),
        .local_frame_o (local_frame)
    );

    always_comb begin
        state_d        = state_q;
        acq_d          = acq_q;
        miss_run_d     = miss_run_q;
        sof_timer_d    = sof_timer_q;
        host_timeout_d = host_timeout_q;
        frame_err_d    = 1'b0;
        missed_d       = missed_q;
        if (32'(sof_timer_q) <= TIMEOUT_CYCLES) begin
            sof_timer_d = sof_timer_q + TW'(1);
        end

        case (state_q)
            ABSENT: begin
                if (sof) begin
                    state_d = ACQUIRE;
                    acq_d   = AW'(1);
                end
            end
            ACQUIRE: begin
                if (sof) begin
                    acq_d = acq_next;
                    if (acq_next == AW'(PRESENT_SOFS)) begin
                        state_d    = PRESENT;
                        miss_run_d = '0;
                    end
                end else if (32'(sof_timer_q) >= WINDOW_CYCLES + TOL_CYCLES) begin
                    state_d = ABSENT;
                    acq_d   = '0;
                end
            end
            PRESENT: begin
                if (sof) begin
                    miss_run_d = '0;
                    if ((frame_index != frame_exp) || !tick_in_window) begin
                        frame_err_d = 1'b1;
                    end
                end else if (synth_fire) begin
                    if (missed_q != '1) begin
                        missed_d = missed_q + MISS_W'(1);
                    end
                    if (miss_run_q == SW'(SUSPEND_FRAMES - 1)) begin
                        state_d    = SUSPENDED;
                        miss_run_d = '0;
                    end else begin
                        miss_run_d = miss_run_q + SW'(1);
                    end
                end
            end
            SUSPENDED: begin
                if (sof) begin
                    state_d = ACQUIRE;
                    acq_d   = AW'(1);
                end
            end
            default: state_d = ABSENT;
        endcase

        if (sof) begin
            sof_timer_d    = '0;
            host_timeout_d = 1'b0;
        end
        if (clear_stats) begin
            missed_d = '0;
        end
        if (timeout_hit) begin
            state_d        = ABSENT;
            acq_d          = '0;
            miss_run_d     = '0;
            host_timeout_d = 1'b1;
        end
        if (bus_reset) begin
            state_d     = ACQUIRE;
            acq_d       = '0;
            miss_run_d  = '0;
            sof_timer_d = '0;
            frame_err_d = 1'b0;
        end

        host_present_d = (state_d == PRESENT) || (state_d == SUSPENDED);
        suspended_d    = (state_d == SUSPENDED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ABSENT;
            acq_q          <= '0;
            miss_run_q     <= '0;
            sof_timer_q    <= '0;
            host_present_q <= 1'b0;
            host_timeout_q <= 1'b0;
            suspended_q    <= 1'b0;
            frame_err_q    <= 1'b0;
            missed_q       <= '0;
        end else begin
            state_q        <= state_d;
            acq_q          <= acq_d;
            miss_run_q     <= miss_run_d;
            sof_timer_q    <= sof_timer_d;
            host_present_q <= host_present_d;
            host_timeout_q <= host_timeout_d;
            suspended_q    <= suspended_d;
            frame_err_q    <= frame_err_d;
            missed_q       <= missed_d;
        end
    end

    assign host_present  = host_present_q;
    assign host_timeout  = host_timeout_q;
    assign suspended     = suspended_q;
    assign frame_err     = frame_err_q;
    assign missed_frames = missed_q;

endmodule
